board_clear_ctrl: RTL and testbench
===================================

# board_clear_ctrl

Line-clear sequencer for one player's 20x10 Tetris board RAM, shared with the VGA display read path. On `start` (after a piece locks) it scans the board bottom-up, removes every full row, compacts the rows above downward, zero-fills the vacated top rows, and reports the number of rows cleared to the score logic. The display always wins the single RAM port. The controller stalls whenever `disp_req` is high, so the picture never glitches. The design instantiates one of these per player.

## Interface
- `ROWS`, 20: board rows; row 0 is the top.
- `COLS`, 10: board columns; cell address = row*COLS + col.
- `AW`, 8: RAM address width.
- `CW`, 5: cell width; 0 means empty, and any nonzero value is an occupied colour/type.
- `pclk`, in, 1: single clock.
- `rstn`, in, 1: asynchronous, active-low reset.
- `start`, in, 1: single-cycle request to run a clear pass.
- `busy`, out, 1: high from the cycle after `start` is accepted until `done`, inclusive.
- `done`, out, 1: one-cycle pulse when the pass is complete.
- `lines`, out, 5: rows cleared by the last pass (0..ROWS); held until the next accepted `start`.
- `disp_req`, in, 1: the display needs the RAM this cycle (active video inside the board window).
- `disp_addr`, in, AW: display read address.
- `ram_addr`, out, AW: RAM address.
- `ram_we`, out, 1: RAM write enable.
- `ram_wdata`, out, CW: RAM write data.
- `ram_rdata`, in, CW: RAM read data, valid 1 cycle after the address.

## Operation
- **Port mux** (combinational):
  - When `disp_req`=1: `ram_addr`=`disp_addr`, `ram_we`=0.
  - Otherwise `ram_addr`, `ram_we` and `ram_wdata` come from the controller.
  - A controller access happens only on a granted cycle (`disp_req`=0).
- **Read pipeline:**
  - A one-bit valid flag registers "granted read issued".
  - `ram_rdata` is captured into the row buffer (COLS x CW) at column index `rcol_d` the following cycle, whether or not that cycle is granted.
- **Pointers:** `src` and `dst` are both 5-bit row pointers, both initialised to ROWS-1. The invariant `dst >= src` always holds, so a write never destroys an unread row.
- **FSM:**
  - **IDLE**: `start`=1 → READ, clearing `src`, `dst`, `cnt` and `lines`. `start` is ignored in any other state.
  - **READ**: issues reads of row `src`, columns 0..COLS-1, one per granted cycle. Moves to CHECK once all COLS data words have been captured.
  - **CHECK** (1 cycle), where full means every buffered cell is nonzero:
    - Full: `cnt`++, and `dst` is unchanged.
    - Not full with `dst`==`src`: `dst`--.
    - Not full with `dst`!=`src`: go to WRITE.
    - Then, if no WRITE is needed: if `src`==0, go to CLEAR (or DONE if `dst` has wrapped below 0); otherwise `src`--, → READ.
  - **WRITE**: writes buffer columns 0..COLS-1 into row `dst`, one per granted cycle. Afterwards `dst`-- and the same src==0 decision as CHECK applies.
  - **CLEAR**: writes 0 to every cell of rows `dst`..0, row-descending and column-ascending, one per granted cycle → DONE.
  - **DONE** (1 cycle): `done`=1, `lines`=`cnt` → IDLE.
- **Arithmetic and widths:**
  - `dst` uses a signed 6-bit shadow so that "below row 0" is detectable.
  - Addresses are computed as row*COLS+col in AW bits; the maximum is 199.
- **Boundary conditions:**
  - `start` arriving together with `disp_req` is still accepted.
  - A stall in mid-row holds the column counters. There is no timeout.
  - Reset mid-pass returns the block to IDLE with all outputs at their reset values. RAM contents stay partially compacted (not restored); the game restarts the board on reset.
  - A board with all rows full gives `lines`=20, with every row zeroed by CLEAR.

## Timing
- Reset values: `busy`=0, `done`=0, `lines`=0, `ram_we`=0, `ram_wdata`=0. Controller address is 0, so `ram_addr` follows `disp_addr` or is 0.
- Cycle counts with no stalls:
  - READ: COLS+1 cycles.
  - CHECK: 1 cycle.
  - WRITE: COLS cycles.
  - CLEAR: COLS cycles per row.
  - DONE: 1 cycle.
- `start` is sampled at cycle 0 and READ begins at cycle 1.
- Each cycle with `disp_req`=1 adds exactly one cycle to any in-flight READ, WRITE or CLEAR issue.
- Write data and address are presented in the same cycle; the RAM commits them on that edge.

## Structure
- Shared package `tetris_pkg` holds:
  - `BOARD_ROWS`, `BOARD_COLS`, `CELL_W` and `BOARD_AW`.
  - The `clr_state_t` enum: IDLE, READ, CHECK, WRITE, CLEAR, DONE.
- The port mux plus the read-valid register form the natural sub-module `board_port_mux`, which is reusable for the falling-piece collision checker.

## Test plan
- **Empty board**, `start`, `disp_req`=0 → `lines`=0, `done` at cycle 241, RAM unchanged, no `ram_we` pulses.
- **Full bottom row:** row 19 full, row 18 has cell (18,3)=5, the rest empty → `done` at cycle 441, `lines`=1, cell (19,3)=5, row 0 all 0.
- **Two non-adjacent full rows:** rows 17 and 19 full, row 18 = pattern P → `lines`=2, row 19 = P, rows 0..18 zero.
- **Display priority:** `disp_req` toggled 1/0 every cycle during a pass → `ram_we`=0 on every `disp_req` cycle, `ram_addr`=`disp_addr` there, final RAM identical to the unstalled run, `done` delayed.
- **All 20 rows full** → `lines`=20, the whole board 0.
- **Reset and retrigger:** `rstn` low at cycle 100 of a pass → `busy`/`done`/`lines` all 0 next cycle. A second `start` while `busy` is ignored, with `lines` unchanged until the pass completes.

Source files
------------

// File: rtl/tetris_pkg.sv
// rtl/tetris_pkg.sv - board geometry and line-clear sequencer state encoding
package tetris_pkg;
  localparam int BOARD_ROWS = 20;
  localparam int BOARD_COLS = 10;
  localparam int CELL_W     = 5;
  localparam int BOARD_AW   = 8;

  typedef enum logic [2:0] {
    IDLE,
    READ,
    CHECK,
    WRITE,
    CLEAR,
    DONE
  } clr_state_t;
endpackage

// File: rtl/board_port_mux.sv
// rtl/board_port_mux.sv - single-port board RAM arbiter, display always wins
module board_port_mux
  import tetris_pkg::*;
#(
  parameter int AW  = BOARD_AW,
  parameter int CW  = CELL_W,
  parameter int CLW = 4
) (
  input  logic           pclk,
  input  logic           rstn,
  input  logic           disp_req,
  input  logic [AW-1:0]  disp_addr,
  input  logic [AW-1:0]  ctl_addr,
  input  logic           ctl_we,
  input  logic [CW-1:0]  ctl_wdata,
  input  logic           ctl_re,
  input  logic [CLW-1:0] ctl_col,
  output logic           grant,
  output logic [AW-1:0]  ram_addr,
  output logic           ram_we,
  output logic [CW-1:0]  ram_wdata,
  output logic           rd_valid,
  output logic [CLW-1:0] rd_col
);
  assign grant     = !disp_req;
  assign ram_addr  = disp_req ? disp_addr : ctl_addr;
  assign ram_we    = ctl_we & grant;
  assign ram_wdata = ctl_wdata;

  // rd_valid/rd_col tag the word that arrives on ram_rdata next cycle
  always_ff @(posedge pclk or negedge rstn) begin
    if (!rstn) begin
      rd_valid <= 1'b0;
      rd_col   <= '0;
    end else begin
      rd_valid <= ctl_re & grant;
      if (ctl_re && grant) rd_col <= ctl_col;
    end
  end
endmodule

// File: rtl/board_clear_ctrl.sv
// rtl/board_clear_ctrl.sv - bottom-up full-row removal and compaction of one board
module board_clear_ctrl
  import tetris_pkg::*;
#(
  parameter int ROWS = BOARD_ROWS,
  parameter int COLS = BOARD_COLS,
  parameter int AW   = BOARD_AW,
  parameter int CW   = CELL_W
) (
  input  logic          pclk,
  input  logic          rstn,
  input  logic          start,
  output logic          busy,
  output logic          done,
  output logic [4:0]    lines,
  input  logic          disp_req,
  input  logic [AW-1:0] disp_addr,
  output logic [AW-1:0] ram_addr,
  output logic          ram_we,
  output logic [CW-1:0] ram_wdata,
  input  logic [CW-1:0] ram_rdata
);
  localparam int CLW = $clog2(COLS + 1);
  localparam logic [CLW-1:0]    LAST_COL = CLW'(COLS - 1);
  localparam logic [CLW-1:0]    NCOL     = CLW'(COLS);
  localparam logic [4:0]        TOP_SRC  = 5'(ROWS - 1);
  localparam logic signed [5:0] TOP_DST  = 6'(ROWS - 1);

  clr_state_t state, state_nx;

  logic [4:0]        src;
  logic signed [5:0] dst;
  logic signed [5:0] dst_after;
  logic [4:0]        cnt;
  logic [CLW-1:0]    icol;
  logic [CW-1:0]     rbuf [COLS];

  logic [AW-1:0]  ctl_addr;
  logic           ctl_we;
  logic [CW-1:0]  ctl_wdata;
  logic           ctl_re;
  logic           grant;
  logic           rd_valid;
  logic [CLW-1:0] rd_col;

  logic col_adv, src_dec, dst_dec, cnt_inc, row_end, row_full;

  function automatic logic [AW-1:0] cell_addr(input logic [4:0] row, input logic [CLW-1:0] col);
    return AW'(row) * AW'(COLS) + AW'(col);
  endfunction

  board_port_mux #(.AW(AW), .CW(CW), .CLW(CLW)) u_mux (
    .pclk      (pclk),
    .rstn      (rstn),
    .disp_req  (disp_req),
    .disp_addr (disp_addr),
    .ctl_addr  (ctl_addr),
    .ctl_we    (ctl_we),
    .ctl_wdata (ctl_wdata),
    .ctl_re    (ctl_re),
    .ctl_col   (icol),
    .grant     (grant),
    .ram_addr  (ram_addr),
    .ram_we    (ram_we),
    .ram_wdata (ram_wdata),
    .rd_valid  (rd_valid),
    .rd_col    (rd_col)
  );

  always_comb begin
    row_full = 1'b1;
    for (int c = 0; c < COLS; c++) begin
      if (rbuf[c] == '0) row_full = 1'b0;
    end
  end

  always_ff @(posedge pclk or negedge rstn) begin
    if (!rstn) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    ctl_addr  = '0;
    ctl_we    = 1'b0;
    ctl_wdata = '0;
    ctl_re    = 1'b0;
    col_adv   = 1'b0;
    src_dec   = 1'b0;
    dst_dec   = 1'b0;
    cnt_inc   = 1'b0;
    row_end   = 1'b0;
    dst_after = dst;
    unique case (state)
      IDLE: if (start) state_nx = READ;
      READ: begin
        if (icol != NCOL) begin
          ctl_re   = 1'b1;
          ctl_addr = cell_addr(src, icol);
          col_adv  = 1'b1;
        end
        if (rd_valid && rd_col == LAST_COL) state_nx = CHECK;
      end
      CHECK: begin
        if (row_full) begin
          cnt_inc = 1'b1;
          row_end = 1'b1;
        end else if (dst == $signed({1'b0, src})) begin
          dst_dec   = 1'b1;
          dst_after = dst - 6'sd1;
          row_end   = 1'b1;
        end else begin
          state_nx = WRITE;
        end
      end
      WRITE: begin
        ctl_we    = 1'b1;
        ctl_addr  = cell_addr(dst[4:0], icol);
        ctl_wdata = rbuf[icol];
        col_adv   = 1'b1;
        if (grant && icol == LAST_COL) begin
          dst_dec   = 1'b1;
          dst_after = dst - 6'sd1;
          row_end   = 1'b1;
        end
      end
      CLEAR: begin
        ctl_we   = 1'b1;
        ctl_addr = cell_addr(dst[4:0], icol);
        col_adv  = 1'b1;
        if (grant && icol == LAST_COL) begin
          if (dst == 6'sd0) state_nx = DONE;
          else              dst_dec  = 1'b1;
        end
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
    // a negative dst means no row is left to zero-fill
    if (row_end) begin
      if (src == '0) begin
        state_nx = dst_after[5] ? DONE : CLEAR;
      end else begin
        src_dec  = 1'b1;
        state_nx = READ;
      end
    end
  end

  always_ff @(posedge pclk or negedge rstn) begin
    if (!rstn) begin
      src   <= TOP_SRC;
      dst   <= TOP_DST;
      cnt   <= '0;
      lines <= '0;
      icol  <= '0;
    end else begin
      if (state == IDLE && start) begin
        src   <= TOP_SRC;
        dst   <= TOP_DST;
        cnt   <= '0;
        lines <= '0;
      end
      if (src_dec) src <= src - 5'd1;
      if (dst_dec) dst <= dst - 6'sd1;
      if (cnt_inc) cnt <= cnt + 5'd1;
      if (state == DONE) lines <= cnt;
      // CLEAR walks several rows without leaving the state, so wrap the column there
      if (state_nx != state) icol <= '0;
      else if (grant && col_adv)
        icol <= (icol == LAST_COL && state == CLEAR) ? '0 : icol + CLW'(1);
    end
  end

  always_ff @(posedge pclk) begin
    if (rd_valid) rbuf[rd_col] <= ram_rdata;
  end

  assign busy = (state != IDLE);
  assign done = (state == DONE);
endmodule

// File: tb/tb_board_clear_ctrl.sv
// tb/tb_board_clear_ctrl.sv - randomized self-checking bench for board_clear_ctrl
module tb_board_clear_ctrl;
  localparam int R = 20;
  localparam int C = 10;
  localparam int N = R * C;

  logic       pclk = 1'b0;
  logic       rstn = 1'b0;
  logic       start = 1'b0;
  logic       disp_req = 1'b0;
  logic [7:0] disp_addr = '0;
  logic       busy, done, ram_we;
  logic [4:0] lines, ram_wdata;
  logic [7:0] ram_addr;
  logic [4:0] ram_rdata = '0;
  logic       load = 1'b0;

  logic [4:0] mem    [N];
  logic [4:0] init_b [N];
  logic [4:0] exp_b  [N];
  int exp_lines, exp_cyc;
  int n_chk = 0;
  int n_pass = 0;

  always #5 pclk = ~pclk;

  board_clear_ctrl dut (
    .pclk      (pclk),
    .rstn      (rstn),
    .start     (start),
    .busy      (busy),
    .done      (done),
    .lines     (lines),
    .disp_req  (disp_req),
    .disp_addr (disp_addr),
    .ram_addr  (ram_addr),
    .ram_we    (ram_we),
    .ram_wdata (ram_wdata),
    .ram_rdata (ram_rdata)
  );

  always @(posedge pclk) begin
    ram_rdata <= mem[ram_addr];
    if (load) begin
      for (int i = 0; i < N; i++) mem[i] <= init_b[i];
    end else if (ram_we) begin
      mem[ram_addr] <= ram_wdata;
    end
  end

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  // Reference: keep non-full rows in bottom-up order, pad the top with zeros.
  task automatic build_model();
    int k, fc;
    bit full;
    for (int i = 0; i < N; i++) exp_b[i] = '0;
    k = R - 1;
    fc = 0;
    exp_cyc = 0;
    for (int r = R - 1; r >= 0; r--) begin
      full = 1'b1;
      for (int c = 0; c < C; c++) if (init_b[r*C+c] == 0) full = 1'b0;
      exp_cyc += C + 2;
      if (full) fc++;
      else begin
        if (fc > 0) exp_cyc += C;
        for (int c = 0; c < C; c++) exp_b[k*C+c] = init_b[r*C+c];
        k--;
      end
    end
    exp_cyc += C * fc + 1;
    exp_lines = fc;
  endtask

  task automatic gen_board(input int mode);
    for (int i = 0; i < N; i++) init_b[i] = '0;
    case (mode)
      1: begin
        for (int c = 0; c < C; c++) init_b[19*C+c] = 5'($urandom_range(1, 31));
        init_b[18*C+3] = 5'd5;
      end
      2: begin
        for (int c = 0; c < C; c++) begin
          init_b[19*C+c] = 5'($urandom_range(1, 31));
          init_b[17*C+c] = 5'($urandom_range(1, 31));
          init_b[18*C+c] = (c % 3 == 0) ? 5'd0 : 5'(c + 1);
        end
      end
      3: for (int i = 0; i < N; i++) init_b[i] = 5'($urandom_range(1, 31));
      4: begin
        for (int r = 0; r < R; r++) begin
          bit fullrow;
          fullrow = ($urandom_range(0, 2) == 0);
          for (int c = 0; c < C; c++)
            init_b[r*C+c] = (fullrow || $urandom_range(0, 1) == 1) ? 5'($urandom_range(1, 31)) : 5'd0;
        end
      end
      default: ;
    endcase
    @(negedge pclk); load = 1'b1;
    @(negedge pclk); load = 1'b0;
    build_model();
  endtask

  function automatic int ram_bad();
    int b = 0;
    for (int i = 0; i < N; i++) if (mem[i] !== exp_b[i]) b++;
    return b;
  endfunction

  task automatic run_pass(input bit tog, input int retrig_at, input int rst_at, output int we_cnt);
    int cyc, dcyc, busy_bad, lines_bad, prio_bad;
    dcyc = -1; busy_bad = 0; lines_bad = 0; prio_bad = 0; we_cnt = 0;
    @(negedge pclk);
    start = 1'b1;
    if (tog) begin disp_req = 1'b1; disp_addr = 8'($urandom_range(0, N - 1)); end
    cyc = 0;
    while (dcyc < 0 && cyc < 5000) begin
      @(posedge pclk); cyc++; #1;
      start = (cyc == retrig_at);
      if (tog) begin
        disp_req  = (cyc % 2 == 0);
        disp_addr = 8'($urandom_range(0, N - 1));
      end
      if (cyc == rst_at) begin
        rstn = 1'b0;
        @(negedge pclk); @(negedge pclk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_lines", lines, 0);
        chk("rst_we", ram_we, 0);
        rstn = 1'b1; start = 1'b0; disp_req = 1'b0;
        return;
      end
      @(negedge pclk);
      if (!busy) busy_bad++;
      if (lines != 0) lines_bad++;
      if (ram_we) we_cnt++;
      if (disp_req && (ram_we || ram_addr != disp_addr)) prio_bad++;
      if (done) dcyc = cyc;
    end
    start = 1'b0; disp_req = 1'b0;
    chk("done_seen", int'(dcyc >= 0), 1);
    if (tog) chk("stall_delay", int'(dcyc > exp_cyc), 1);
    else     chk("done_cycle", dcyc, exp_cyc);
    chk("busy_during", busy_bad, 0);
    chk("lines_during", lines_bad, 0);
    if (tog) chk("disp_priority", prio_bad, 0);
    repeat (3) @(negedge pclk);
    chk("busy_after", busy, 0);
    chk("done_after", done, 0);
    chk("lines", lines, exp_lines);
    chk("ram_cells", ram_bad(), 0);
  endtask

  initial begin
    int we;
    repeat (2) @(negedge pclk);
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_lines", lines, 0);
    chk("reset_we", ram_we, 0);
    chk("reset_wdata", ram_wdata, 0);
    chk("reset_addr", ram_addr, 0);
    disp_req = 1'b1; disp_addr = 8'd77; #1;
    chk("reset_disp_addr", ram_addr, 77);
    disp_req = 1'b0;
    rstn = 1'b1;

    gen_board(0); run_pass(1'b0, -1, -1, we);
    chk("empty_no_we", we, 0);
    chk("empty_done_241", exp_cyc, 241);

    gen_board(1); run_pass(1'b0, -1, -1, we);
    chk("cell_19_3", mem[19*C+3], 5);
    chk("cell_0_3", mem[3], 0);

    gen_board(2); run_pass(1'b0, -1, -1, we);
    chk("two_rows_lines", lines, 2);

    gen_board(2); run_pass(1'b1, -1, -1, we);
    gen_board(4); run_pass(1'b1, -1, -1, we);

    gen_board(3); run_pass(1'b0, -1, -1, we);
    chk("all_full_lines", lines, 20);
    @(negedge pclk); rstn = 1'b0;
    @(negedge pclk);
    chk("idle_rst_lines", lines, 0);
    rstn = 1'b1;

    for (int t = 0; t < 4; t++) begin
      gen_board(4); run_pass(1'b0, (t == 1) ? 50 : -1, -1, we);
    end

    gen_board(4); run_pass(1'b0, -1, 100, we);
    gen_board(4); run_pass(1'b0, -1, -1, we);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
